// File: rtl/bus_map_pkg.sv
// Address map and bus widths shared by the data-bus responder and its peripherals.
package bus_map_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  typedef enum logic [3:0] {
    REG_RAM = 4'h0,
    REG_LED = 4'h1,
    REG_SEG = 4'h2,
    REG_SW  = 4'h3,
    REG_TMR = 4'h4
  } region_e;

  localparam logic TMR_COUNT  = 1'b0;
  localparam logic TMR_STATUS = 1'b1;
endpackage

// File: rtl/mmio_timer.sv
// Prescaled down-counter with auto-reload and a sticky, write-1-to-clear expiry flag.
module mmio_timer
  import bus_map_pkg::*;
#(
  parameter int CLK_DIV = 50000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_count,
  input  logic              clr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] count,
  output logic              expired
);
  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);

  logic [DATA_W-1:0] reload;
  logic [PW-1:0]     presc;
  logic              running, tick, expire;

  assign running = (reload != '0);
  assign tick    = running && (presc == PMAX);
  // A COUNT write discards any tick landing on the same edge.
  assign expire  = tick && !wr_count && (count <= DATA_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reload  <= '0;
      count   <= '0;
      presc   <= '0;
      expired <= 1'b0;
    end else begin
      if (wr_count) begin
        reload <= wdata;
        count  <= wdata;
        presc  <= '0;
      end else if (running) begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick) count <= (count > DATA_W'(1)) ? count - 1'b1 : reload;
      end
      // Set has priority over a simultaneous clear.
      if (expire)   expired <= 1'b1;
      else if (clr) expired <= 1'b0;
    end
  end
endmodule

// File: rtl/mem_bus_responder.sv
// Data-bus responder: word RAM, LED/SEG registers, synchronised switches and timer behind a 1-edge read.
module mem_bus_responder
  import bus_map_pkg::*;
#(
  parameter int RAM_DEPTH = 256,
  parameter int CLK_DIV   = 50000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DOUT,
  input  logic              W,
  input  logic [9:0]        SW,
  output logic [DATA_W-1:0] DIN,
  output logic [9:0]        LEDR,
  output logic [DATA_W-1:0] SEG
);
  localparam int IDX_W = $clog2(RAM_DEPTH);

  logic [3:0]        region;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] mem [RAM_DEPTH];
  logic [DATA_W-1:0] ram_q, io_q, io_next, tmr_count;
  logic              rd_ram_q, tmr_expired, tmr_wr, tmr_clr;
  logic [9:0]        sw_meta, sw_sync;

  assign region = ADDR[15:12];
  assign idx    = ADDR[IDX_W-1:0];

  if (IDX_W < 12) begin : g_alias
    logic unused_alias;
    assign unused_alias = ^ADDR[11:IDX_W];
  end

  assign tmr_wr  = W && (region == REG_TMR) && (ADDR[0] == TMR_COUNT);
  assign tmr_clr = W && (region == REG_TMR) && (ADDR[0] == TMR_STATUS) && DOUT[0];

  mmio_timer #(.CLK_DIV(CLK_DIV)) u_tmr (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_count (tmr_wr),
    .clr      (tmr_clr),
    .wdata    (DOUT),
    .count    (tmr_count),
    .expired  (tmr_expired)
  );

  // Read-first single-port RAM; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (W && reset_n && (region == REG_RAM)) mem[idx] <= DOUT;
    ram_q <= mem[idx];
  end

  always_comb begin
    io_next = '0;
    case (region)
      REG_LED: io_next = {6'b0, LEDR};
      REG_SEG: io_next = SEG;
      REG_SW:  io_next = {6'b0, sw_sync};
      REG_TMR: io_next = (ADDR[0] == TMR_STATUS) ? {15'b0, tmr_expired} : tmr_count;
      default: io_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ram_q <= 1'b0;
      io_q     <= '0;
      LEDR     <= '0;
      SEG      <= '0;
      sw_meta  <= '0;
      sw_sync  <= '0;
    end else begin
      rd_ram_q <= (region == REG_RAM);
      io_q     <= io_next;
      sw_meta  <= SW;
      sw_sync  <= sw_meta;
      if (W && (region == REG_LED)) LEDR <= DOUT[9:0];
      if (W && (region == REG_SEG)) SEG  <= DOUT;
    end
  end

  // RAM data comes straight from its output register so read latency stays one edge.
  assign DIN = rd_ram_q ? ram_q : io_q;
endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: table of bus accesses plus switch, timer and reset sequences.
module tb_mem_bus_responder;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] ADDR, DOUT, DIN, SEG;
  logic        W;
  logic [9:0]  SW, LEDR;

  int errors = 0;
  int checks = 0;

  mem_bus_responder #(.RAM_DEPTH(256), .CLK_DIV(4)) dut (
    .clk(clk), .reset_n(reset_n), .ADDR(ADDR), .DOUT(DOUT), .W(W),
    .SW(SW), .DIN(DIN), .LEDR(LEDR), .SEG(SEG)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] dout;
    logic        w;
    logic        chk_din;
    logic [15:0] din;
    logic [9:0]  led;
    logic [15:0] seg;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic [15:0] a, input logic [15:0] d, input logic w);
    @(negedge clk);
    ADDR = a; DOUT = d; W = w;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; ADDR = '0; DOUT = '0; W = 1'b0; SW = '0;

    tbl[0]  = '{16'h0005, 16'hBEEF, 1'b1, 1'b0, 16'h0000, 10'h000, 16'h0000};
    tbl[1]  = '{16'h0005, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 10'h000, 16'h0000};
    tbl[2]  = '{16'h0105, 16'h1234, 1'b1, 1'b1, 16'hBEEF, 10'h000, 16'h0000};
    tbl[3]  = '{16'h0005, 16'h0000, 1'b0, 1'b1, 16'h1234, 10'h000, 16'h0000};
    tbl[4]  = '{16'h1000, 16'hFFFF, 1'b1, 1'b1, 16'h0000, 10'h3FF, 16'h0000};
    tbl[5]  = '{16'h1000, 16'h0000, 1'b0, 1'b1, 16'h03FF, 10'h3FF, 16'h0000};
    tbl[6]  = '{16'h2000, 16'hA5C3, 1'b1, 1'b1, 16'h0000, 10'h3FF, 16'hA5C3};
    tbl[7]  = '{16'h2000, 16'h0000, 1'b0, 1'b1, 16'hA5C3, 10'h3FF, 16'hA5C3};
    tbl[8]  = '{16'h7000, 16'hFFFF, 1'b1, 1'b1, 16'h0000, 10'h3FF, 16'hA5C3};
    tbl[9]  = '{16'h7000, 16'h0000, 1'b0, 1'b1, 16'h0000, 10'h3FF, 16'hA5C3};
    tbl[10] = '{16'h3000, 16'hFFFF, 1'b1, 1'b1, 16'h0000, 10'h3FF, 16'hA5C3};
    tbl[11] = '{16'h5000, 16'h0000, 1'b0, 1'b1, 16'h0000, 10'h3FF, 16'hA5C3};
    tbl[12] = '{16'h0009, 16'h1111, 1'b1, 1'b0, 16'h0000, 10'h3FF, 16'hA5C3};
    tbl[13] = '{16'h0009, 16'h0000, 1'b0, 1'b1, 16'h1111, 10'h3FF, 16'hA5C3};

    // reset state
    @(posedge clk); #1;
    chk("reset_din", DIN, 16'h0000);
    chk("reset_led", {6'b0, LEDR}, 16'h0000);
    chk("reset_seg", SEG, 16'h0000);
    @(negedge clk); reset_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].addr, tbl[i].dout, tbl[i].w);
      if (tbl[i].chk_din) chk($sformatf("vec%0d_din", i), DIN, tbl[i].din);
      chk($sformatf("vec%0d_led", i), {6'b0, LEDR}, {6'b0, tbl[i].led});
      chk($sformatf("vec%0d_seg", i), SEG, tbl[i].seg);
    end

    // switch synchroniser: value visible on DIN from the 3rd edge
    @(negedge clk); SW = 10'h2AA; ADDR = 16'h3000; W = 1'b0;
    @(posedge clk); #1; chk("sw_edge1", DIN, 16'h0000);
    step(16'h3000, 16'h0, 1'b0); chk("sw_edge2", DIN, 16'h0000);
    step(16'h3000, 16'h0, 1'b0); chk("sw_edge3", DIN, 16'h02AA);

    // timer, CLK_DIV=4: write 3 at edge 0, ticks every 4 edges
    step(16'h4000, 16'd3, 1'b1);
    for (int k = 1; k <= 11; k++) begin
      step(16'h4000, 16'h0, 1'b0);
      chk($sformatf("tmr_cnt_e%0d", k), DIN, (k <= 4) ? 16'd3 : (k <= 8) ? 16'd2 : 16'd1);
    end
    step(16'h4001, 16'h0, 1'b0); chk("tmr_stat_e12", DIN, 16'd0);
    step(16'h4001, 16'h0, 1'b0); chk("tmr_stat_e13", DIN, 16'd1);
    step(16'h4000, 16'h0, 1'b0); chk("tmr_reload_e14", DIN, 16'd3);
    step(16'h4001, 16'h1, 1'b1); chk("tmr_clr_rdfirst", DIN, 16'd1);
    step(16'h4001, 16'h0, 1'b0); chk("tmr_clr_done", DIN, 16'd0);
    for (int k = 17; k <= 23; k++) begin
      step(16'h4000, 16'h0, 1'b0);
      chk($sformatf("tmr_cnt_e%0d", k), DIN, (k <= 20) ? 16'd2 : 16'd1);
    end
    // clear on the expiry edge: set wins
    step(16'h4001, 16'h1, 1'b1); chk("tmr_clr_on_exp_old", DIN, 16'd0);
    step(16'h4001, 16'h0, 1'b0); chk("tmr_set_wins", DIN, 16'd1);
    step(16'h4001, 16'h1, 1'b1); chk("tmr_clr2", DIN, 16'd1);
    step(16'h4000, 16'h0, 1'b0); chk("tmr_cnt_e27", DIN, 16'd3);
    // rewrite on a tick edge (edge 28)
    step(16'h4000, 16'd5, 1'b1); chk("tmr_rw_tick_old", DIN, 16'd3);
    for (int k = 29; k <= 32; k++) begin
      step(16'h4000, 16'h0, 1'b0);
      chk($sformatf("tmr_rw_e%0d", k), DIN, 16'd5);
    end
    step(16'h4000, 16'h0, 1'b0); chk("tmr_rw_e33", DIN, 16'd4);
    // rewrite mid-period restarts prescaler
    step(16'h4000, 16'd2, 1'b1); chk("tmr_rw2_old", DIN, 16'd4);
    for (int k = 35; k <= 38; k++) begin
      step(16'h4000, 16'h0, 1'b0);
      chk($sformatf("tmr_presc_e%0d", k), DIN, 16'd2);
    end
    step(16'h4000, 16'h0, 1'b0); chk("tmr_presc_e39", DIN, 16'd1);

    // stop: reload 0
    step(16'h4000, 16'd0, 1'b1); chk("tmr_stop_old", DIN, 16'd1);
    step(16'h4001, 16'h1, 1'b1); chk("tmr_stop_stat", DIN, 16'd0);
    for (int k = 0; k < 100; k++) begin
      step((k % 2) ? 16'h4001 : 16'h4000, 16'h0, 1'b0);
      chk($sformatf("tmr_stopped_%0d", k), DIN, 16'd0);
    end

    // reset asserted during writes: nothing is written
    @(negedge clk);
    reset_n = 1'b0; ADDR = 16'h1000; DOUT = 16'h0155; W = 1'b1;
    #1;
    chk("rst_mid_din", DIN, 16'h0000);
    chk("rst_mid_led", {6'b0, LEDR}, 16'h0000);
    chk("rst_mid_seg", SEG, 16'h0000);
    @(posedge clk); #1;
    step(16'h0009, 16'h2222, 1'b1);
    step(16'h1000, 16'h0155, 1'b1);
    chk("rst_hold_led", {6'b0, LEDR}, 16'h0000);
    @(negedge clk); reset_n = 1'b1; ADDR = 16'h1000; W = 1'b0;
    @(posedge clk); #1;
    chk("rst_rel_din", DIN, 16'h0000);
    chk("rst_rel_led", {6'b0, LEDR}, 16'h0000);
    step(16'h0009, 16'h0, 1'b0); chk("rst_ram_kept", DIN, 16'h1111);
    step(16'h2000, 16'h0, 1'b0); chk("rst_seg_read", DIN, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
